seq_div: RTL
============

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: dividend.
REQ-007 SHALL have port b, input, WIDTH bits: divisor.
REQ-008 SHALL have port signed_op, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid, output, 1 bit: results are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the results.
REQ-011 SHALL have port quot, output, WIDTH bits: quotient.
REQ-012 SHALL have port rem, output, WIDTH bits: remainder.
REQ-013 SHALL have port div_by_zero, output, 1 bit: the current result came from b == 0.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on a cycle where in_valid && in_ready; a, b and signed_op are captured then, and later input changes are ignored.
REQ-017 SHALL go from IDLE to BUSY on accept when b != 0, and from IDLE to DONE on accept when b == 0.
REQ-018 SHALL perform one restoring shift-subtract iteration per cycle in BUSY on operand magnitudes, using a WIDTH+1-bit partial remainder and a counter running 0..WIDTH-1.
REQ-019 SHALL leave BUSY for DONE after exactly WIDTH iterations, so out_valid rises WIDTH+1 cycles after the accept edge (divide-by-zero case: 1 cycle).
REQ-020 SHALL apply the sign fix-up in signed mode when entering DONE: quotient negated when the operand signs differ, remainder takes the sign of the dividend (truncation toward zero).
REQ-021 SHALL produce, for b == 0: quot = all ones, rem = a, div_by_zero = 1, in both modes.
REQ-022 SHALL produce, for signed overflow (a = most-negative, b = -1): quot = most-negative, rem = 0, div_by_zero = 0.
REQ-023 SHALL compute the magnitude of the most-negative value as the unsigned value 2^(WIDTH-1), with no overflow.
REQ-024 SHALL hold quot, rem and div_by_zero stable in DONE while out_ready = 0, for any number of cycles.
REQ-025 SHALL return from DONE to IDLE on out_valid && out_ready; in_ready is 1 on the following cycle, with no same-cycle re-accept.
REQ-026 SHALL ignore in_valid in BUSY and DONE, and ignore out_ready outside DONE.
REQ-027 SHALL keep quot, rem and div_by_zero at their last DONE values while in IDLE and BUSY.
REQ-028 SHALL process a = 0 through the normal WIDTH-cycle path, giving quot = 0, rem = 0.

Reset
REQ-029 SHALL, when reset_n = 0 at a rising clk edge, force state = IDLE, counter = 0, quot = 0, rem = 0, div_by_zero = 0, out_valid = 0, in_ready = 1 from the next cycle.
REQ-030 SHALL let reset override everything, including mid-BUSY and in DONE with out_ready low; the in-flight operation is discarded with no result produced.
REQ-031 SHALL allow the first accept on the first cycle with reset_n = 1.

Verification (WIDTH = 8)
REQ-032 SHALL verify unsigned: a = 200, b = 7, signed_op = 0 -> quot = 28, rem = 4, div_by_zero = 0, out_valid exactly 9 cycles after the accept.
REQ-033 SHALL verify signed: a = 0xF9 (-7), b = 0x02 -> quot = 0xFD (-3), rem = 0xFF (-1); and a = 0x07, b = 0xFE -> quot = 0xFD, rem = 0x01.
REQ-034 SHALL verify overflow and zero: signed a = 0x80, b = 0xFF -> quot = 0x80, rem = 0x00; a = 55, b = 0 -> quot = 0xFF, rem = 55, div_by_zero = 1, out_valid 1 cycle after the accept.
REQ-035 SHALL verify backpressure: out_ready held 0 for 5 cycles in DONE with a new in_valid pulse -> outputs stable, in_ready = 0, pulse ignored; out_ready = 1 -> IDLE next cycle.
REQ-036 SHALL verify reset mid-operation: reset_n = 0 on the 4th BUSY cycle -> next cycle in_ready = 1, out_valid = 0, quot = rem = 0; a new 100/10 run -> quot = 10, rem = 0.
REQ-037 SHALL verify back-to-back: 10 random operand pairs per mode, out_ready randomly toggled -> every result matches a reference model for truncating division, with no dropped or duplicated results.

Source files
------------

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, signed/unsigned, valid/ready on both sides
module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dq_q, bm_q, quot_q, rem_q;
  logic [WIDTH-1:0] a_mag, b_mag, dq_d, quot_d, rem_d;
  logic [WIDTH:0]   pr_q, pr_d, sh, dif;
  logic             negq_q, negr_q, dbz_q;
  // operand magnitudes, one restoring iteration, and the sign fix-up of its result
  always_comb begin
    a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
    sh     = (pr_q << 1) | {{WIDTH{1'b0}}, dq_q[WIDTH-1]};
    dif    = sh - {1'b0, bm_q};
    pr_d   = dif[WIDTH] ? sh : dif;
    dq_d   = {dq_q[WIDTH-2:0], ~dif[WIDTH]};
    quot_d = negq_q ? -dq_d : dq_d;
    rem_d  = negr_q ? -pr_d[WIDTH-1:0] : pr_d[WIDTH-1:0];
  end
  // control FSM with datapath and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      bm_q    <= '0;
      pr_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (b == '0) begin
            quot_q  <= '1;
            rem_q   <= a;
            dbz_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            dq_q    <= a_mag;
            bm_q    <= b_mag;
            pr_q    <= '0;
            cnt_q   <= '0;
            negq_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_q  <= signed_op && a[WIDTH-1];
            state_q <= BUSY;
          end
        end
        BUSY: begin
          dq_q  <= dq_d;
          pr_q  <= pr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
endmodule
